// File: rtl/memory_stage.sv
// memory_stage: MEM stage of the pipeline, between EX/MEM and MEM/WB.
//
// Owns the 16-bit data memory and the stack pointer. Single-word loads,
// stores, pushes and pops complete in one cycle. A 32-bit PC push
// (write source 10) or PC pop (pc_choose_memory) is split into two word
// accesses by a small FSM. During the first of the two cycles the stage
// raises a combinational stall so that upstream holds its EX/MEM inputs.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   result_in, read_data1_in,   ALU result, Op1 (Rdest), Op2 (Rsrc),
//   read_data2_in, LDM_value_in LDM immediate
//   pc_plus_one_in              return address for a 32-bit push
//   mem_read/mem_write/         access type; push beats pop, and a
//   mem_push/mem_pop            stack op ignores mem_read/mem_write
//   memory_address_select       00/11 result_in, 01 read_data2_in, 10 SP
//   memory_write_src_select     00 rd1, 01 rd2, 10 pc_plus_one_in, 11 LDM
//   pc_choose_memory            with mem_pop: 32-bit PC pop
//   reg_write, outport_enable,  MEM/WB control, passed through
//   wb_sel, reg_write_address
//   mem_data_out, alu_result_out, LDM_value_out   MEM/WB data
//   reg_write_out, outport_enable_out, wb_sel_out,
//   reg_write_address_out       MEM/WB control (bubbled during a stall)
//   popped_pc, pc_load          popped return address and its load strobe
//   stall                       hold EX/MEM inputs this cycle
//   sp_out                      current stack pointer
module memory_stage #(
  parameter int ADDR_W = 11,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       result_in,
  input  logic [15:0]       read_data1_in,
  input  logic [15:0]       read_data2_in,
  input  logic [15:0]       LDM_value_in,
  input  logic [31:0]       pc_plus_one_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_push,
  input  logic              mem_pop,
  input  logic [1:0]        memory_address_select,
  input  logic [1:0]        memory_write_src_select,
  input  logic              pc_choose_memory,
  input  logic              reg_write,
  input  logic              outport_enable,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        reg_write_address,
  output logic [15:0]       mem_data_out,
  output logic [15:0]       alu_result_out,
  output logic [15:0]       LDM_value_out,
  output logic              reg_write_out,
  output logic              outport_enable_out,
  output logic [1:0]        wb_sel_out,
  output logic [2:0]        reg_write_address_out,
  output logic [31:0]       popped_pc,
  output logic              pc_load,
  output logic              stall,
  output logic [ADDR_W-1:0] sp_out
);

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, PUSH2 = 2'd1, POP2 = 2'd2} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] sp, sp_inc, sp_dec, addr;
  logic [DATA_W-1:0] src_data, rd_data, stk_data;
  logic [DATA_W-1:0] lo_word_p1;
  logic              is_push, is_pop, push32, pop32, first_half;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Access decode: push has priority over pop.
  assign is_push = mem_push;
  assign is_pop  = mem_pop & ~mem_push;
  assign push32  = is_push & (memory_write_src_select == 2'b10);
  assign pop32   = is_pop & pc_choose_memory;

  assign sp_inc = sp + SP_ONE;
  assign sp_dec = sp - SP_ONE;

  always_comb begin
    addr = result_in[ADDR_W-1:0];
    case (memory_address_select)
      2'b01:   addr = read_data2_in[ADDR_W-1:0];
      2'b10:   addr = sp;
      default: addr = result_in[ADDR_W-1:0];
    endcase
  end

  always_comb begin
    src_data = read_data1_in;
    case (memory_write_src_select)
      2'b01:   src_data = read_data2_in;
      2'b10:   src_data = pc_plus_one_in[15:0];
      2'b11:   src_data = LDM_value_in;
      default: src_data = read_data1_in;
    endcase
  end

  // Combinational read ports: addressed access and top-of-stack (SP+1).
  assign rd_data  = mem[addr];
  assign stk_data = mem[sp_inc];

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE: begin
        if (push32)     state_next = PUSH2;
        else if (pop32) state_next = POP2;
        else            state_next = IDLE;
      end
      PUSH2:   state_next = IDLE;
      POP2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: stall and the single memory write port
  always_comb begin
    first_half = (state == IDLE) & (push32 | pop32);
    stall      = reset & first_half;
    we         = 1'b0;
    waddr      = sp;
    wdata      = src_data;
    case (state)
      IDLE: begin
        if (is_push) begin
          we    = 1'b1;
          waddr = sp;
          wdata = push32 ? pc_plus_one_in[31:16] : src_data;
        end else if (!is_pop && mem_write) begin
          we    = 1'b1;
          waddr = addr;
          wdata = src_data;
        end
      end
      PUSH2: begin
        we    = 1'b1;
        waddr = sp;
        wdata = lo_word_p1;
      end
      default: ;
    endcase
    // No writes while reset is held.
    we = we & reset;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Low half of a 32-bit push or pop, carried into the second cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (push32)     lo_word_p1 <= pc_plus_one_in[15:0];
      else if (pop32) lo_word_p1 <= stk_data;
    end
  end

  // MEM/WB stage boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp                    <= SP_INIT;
      mem_data_out          <= '0;
      alu_result_out        <= '0;
      LDM_value_out         <= '0;
      reg_write_out         <= 1'b0;
      outport_enable_out    <= 1'b0;
      wb_sel_out            <= '0;
      reg_write_address_out <= '0;
      popped_pc             <= '0;
      pc_load               <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_push)     sp <= sp_dec;
          else if (is_pop) sp <= sp_inc;
        end
        PUSH2:   sp <= sp_dec;
        POP2:    sp <= sp_inc;
        default: ;
      endcase

      if (state == IDLE) begin
        if (is_pop && !pc_choose_memory)
          mem_data_out <= stk_data;
        else if (!is_push && !is_pop && mem_read)
          mem_data_out <= rd_data;
      end

      if (state == POP2) popped_pc <= {stk_data, lo_word_p1};
      pc_load <= (state == POP2);

      // The first cycle of a split access is a bubble for write-back.
      reg_write_out         <= reg_write & ~first_half;
      outport_enable_out    <= outport_enable & ~first_half;
      alu_result_out        <= result_in;
      LDM_value_out         <= LDM_value_in;
      wb_sel_out            <= wb_sel;
      reg_write_address_out <= reg_write_address;
    end
  end

  assign sp_out = sp;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios followed by a
// randomized run against an operation-level model of the memory and stack.
module tb_memory_stage;

  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] result_in, read_data1_in, read_data2_in, LDM_value_in;
  logic [31:0] pc_plus_one_in;
  logic        mem_read, mem_write, mem_push, mem_pop;
  logic [1:0]  memory_address_select, memory_write_src_select;
  logic        pc_choose_memory, reg_write, outport_enable;
  logic [1:0]  wb_sel;
  logic [2:0]  reg_write_address;

  logic [15:0] mem_data_out, alu_result_out, LDM_value_out;
  logic        reg_write_out, outport_enable_out, pc_load, stall;
  logic [1:0]  wb_sel_out;
  logic [2:0]  reg_write_address_out;
  logic [31:0] popped_pc;
  logic [AW-1:0] sp_out;

  logic [15:0] w_mem_data_out, w_alu_result_out, w_LDM_value_out;
  logic        w_reg_write_out, w_outport_enable_out, w_pc_load, w_stall;
  logic [1:0]  w_wb_sel_out;
  logic [2:0]  w_reg_write_address_out;
  logic [31:0] w_popped_pc;
  logic [AW-1:0] w_sp_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_stage #(.ADDR_W(AW), .SP_INIT(11'h7FF)) dut (
    .clk(clk), .reset(reset),
    .result_in(result_in), .read_data1_in(read_data1_in),
    .read_data2_in(read_data2_in), .LDM_value_in(LDM_value_in),
    .pc_plus_one_in(pc_plus_one_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
    .memory_address_select(memory_address_select),
    .memory_write_src_select(memory_write_src_select),
    .pc_choose_memory(pc_choose_memory), .reg_write(reg_write),
    .outport_enable(outport_enable), .wb_sel(wb_sel),
    .reg_write_address(reg_write_address),
    .mem_data_out(mem_data_out), .alu_result_out(alu_result_out),
    .LDM_value_out(LDM_value_out), .reg_write_out(reg_write_out),
    .outport_enable_out(outport_enable_out), .wb_sel_out(wb_sel_out),
    .reg_write_address_out(reg_write_address_out),
    .popped_pc(popped_pc), .pc_load(pc_load), .stall(stall), .sp_out(sp_out)
  );

  memory_stage #(.ADDR_W(AW), .SP_INIT(11'h000)) dut_wrap (
    .clk(clk), .reset(reset),
    .result_in(result_in), .read_data1_in(read_data1_in),
    .read_data2_in(read_data2_in), .LDM_value_in(LDM_value_in),
    .pc_plus_one_in(pc_plus_one_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
    .memory_address_select(memory_address_select),
    .memory_write_src_select(memory_write_src_select),
    .pc_choose_memory(pc_choose_memory), .reg_write(reg_write),
    .outport_enable(outport_enable), .wb_sel(wb_sel),
    .reg_write_address(reg_write_address),
    .mem_data_out(w_mem_data_out), .alu_result_out(w_alu_result_out),
    .LDM_value_out(w_LDM_value_out), .reg_write_out(w_reg_write_out),
    .outport_enable_out(w_outport_enable_out), .wb_sel_out(w_wb_sel_out),
    .reg_write_address_out(w_reg_write_address_out),
    .popped_pc(w_popped_pc), .pc_load(w_pc_load), .stall(w_stall), .sp_out(w_sp_out)
  );

  task automatic idle_inputs();
    result_in = '0; read_data1_in = '0; read_data2_in = '0; LDM_value_in = '0;
    pc_plus_one_in = '0; mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
    memory_address_select = '0; memory_write_src_select = '0;
    pc_choose_memory = 0; reg_write = 0; outport_enable = 0; wb_sel = '0;
    reg_write_address = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse reset asynchronously between edges; leaves the bench just after a negedge.
  task automatic pulse_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (sp_out !== 11'h7FF) begin n_err++; $display("FAIL reset_sp got %h exp 7ff", sp_out); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", stall); end
    n_vec++; if (pc_load !== 1'b0) begin n_err++; $display("FAIL reset_pc_load got %b exp 0", pc_load); end
    n_vec++; if (reg_write_out !== 1'b0) begin n_err++; $display("FAIL reset_reg_write got %b exp 0", reg_write_out); end
    n_vec++; if (mem_data_out !== 16'h0) begin n_err++; $display("FAIL reset_mdo got %h exp 0", mem_data_out); end
    n_vec++; if (popped_pc !== 32'h0) begin n_err++; $display("FAIL reset_popped got %h exp 0", popped_pc); end
    n_vec++; if (w_sp_out !== 11'h000) begin n_err++; $display("FAIL reset_wrap_sp got %h exp 0", w_sp_out); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    mem_write = 1; memory_address_select = 2'b00; result_in = 16'h0010;
    read_data1_in = 16'hBEEF; memory_write_src_select = 2'b00;
    reg_write = 1; wb_sel = 2'b10; reg_write_address = 3'd5; LDM_value_in = 16'h55AA;
    step();
    n_vec++; if (alu_result_out !== 16'h0010) begin n_err++; $display("FAIL wr_alu got %h exp 0010", alu_result_out); end
    n_vec++; if (reg_write_out !== 1'b1) begin n_err++; $display("FAIL wr_regwr got %b exp 1", reg_write_out); end
    n_vec++; if (wb_sel_out !== 2'b10 || reg_write_address_out !== 3'd5 || LDM_value_out !== 16'h55AA) begin
      n_err++; $display("FAIL wr_ctl got %b/%0d/%h exp 10/5/55aa", wb_sel_out, reg_write_address_out, LDM_value_out); end
    mem_write = 0; mem_read = 1;
    step();
    n_vec++; if (mem_data_out !== 16'hBEEF) begin n_err++; $display("FAIL rd_data got %h exp beef", mem_data_out); end
    // Simultaneous read and write returns the old contents.
    mem_write = 1; mem_read = 1; read_data1_in = 16'hCAFE;
    step();
    n_vec++; if (mem_data_out !== 16'hBEEF) begin n_err++; $display("FAIL rdwr_old got %h exp beef", mem_data_out); end
    mem_write = 0;
    step();
    n_vec++; if (mem_data_out !== 16'hCAFE) begin n_err++; $display("FAIL rdwr_new got %h exp cafe", mem_data_out); end
    n_vec++; if (sp_out !== 11'h7FF) begin n_err++; $display("FAIL rdwr_sp got %h exp 7ff", sp_out); end
    idle_inputs();
  endtask

  task automatic test_push_pop16();
    mem_push = 1; memory_write_src_select = 2'b00; read_data1_in = 16'h1234;
    mem_read = 1; result_in = 16'h0010;
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL push16_stall got %b exp 0", stall); end
    step();
    n_vec++; if (sp_out !== 11'h7FE) begin n_err++; $display("FAIL push16_sp got %h exp 7fe", sp_out); end
    n_vec++; if (mem_data_out !== 16'hCAFE) begin n_err++; $display("FAIL push16_ignores_read got %h exp cafe", mem_data_out); end
    mem_push = 0; mem_read = 0; mem_pop = 1;
    step();
    n_vec++; if (mem_data_out !== 16'h1234) begin n_err++; $display("FAIL pop16_data got %h exp 1234", mem_data_out); end
    n_vec++; if (sp_out !== 11'h7FF) begin n_err++; $display("FAIL pop16_sp got %h exp 7ff", sp_out); end
    idle_inputs();
    mem_read = 1; result_in = 16'h07FF;
    step();
    n_vec++; if (mem_data_out !== 16'h1234) begin n_err++; $display("FAIL push16_mem got %h exp 1234", mem_data_out); end
    idle_inputs();
  endtask

  task automatic test_push_pop32();
    mem_push = 1; memory_write_src_select = 2'b10; pc_plus_one_in = 32'h0001_0020;
    reg_write = 1; outport_enable = 1;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL push32_stall1 got %b exp 1", stall); end
    step();
    n_vec++; if (reg_write_out !== 1'b0 || outport_enable_out !== 1'b0) begin
      n_err++; $display("FAIL push32_bubble got %b%b exp 00", reg_write_out, outport_enable_out); end
    n_vec++; if (sp_out !== 11'h7FE) begin n_err++; $display("FAIL push32_sp1 got %h exp 7fe", sp_out); end
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL push32_stall2 got %b exp 0", stall); end
    step();
    n_vec++; if (reg_write_out !== 1'b1 || outport_enable_out !== 1'b1) begin
      n_err++; $display("FAIL push32_second got %b%b exp 11", reg_write_out, outport_enable_out); end
    n_vec++; if (sp_out !== 11'h7FD) begin n_err++; $display("FAIL push32_sp2 got %h exp 7fd", sp_out); end
    idle_inputs(); mem_read = 1; result_in = 16'h07FF;
    step();
    n_vec++; if (mem_data_out !== 16'h0001) begin n_err++; $display("FAIL push32_hi got %h exp 0001", mem_data_out); end
    result_in = 16'h07FE;
    step();
    n_vec++; if (mem_data_out !== 16'h0020) begin n_err++; $display("FAIL push32_lo got %h exp 0020", mem_data_out); end
    idle_inputs(); mem_pop = 1; pc_choose_memory = 1;
    #1;
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL pop32_stall1 got %b exp 1", stall); end
    step();
    n_vec++; if (pc_load !== 1'b0 || sp_out !== 11'h7FE) begin
      n_err++; $display("FAIL pop32_mid got pc_load=%b sp=%h exp 0/7fe", pc_load, sp_out); end
    #1;
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL pop32_stall2 got %b exp 0", stall); end
    step();
    n_vec++; if (pc_load !== 1'b1) begin n_err++; $display("FAIL pop32_load got %b exp 1", pc_load); end
    n_vec++; if (popped_pc !== 32'h0001_0020) begin n_err++; $display("FAIL pop32_pc got %h exp 00010020", popped_pc); end
    n_vec++; if (sp_out !== 11'h7FF) begin n_err++; $display("FAIL pop32_sp got %h exp 7ff", sp_out); end
    idle_inputs();
    step();
    n_vec++; if (pc_load !== 1'b0) begin n_err++; $display("FAIL pop32_load_off got %b exp 0", pc_load); end
    n_vec++; if (popped_pc !== 32'h0001_0020) begin n_err++; $display("FAIL pop32_hold got %h exp 00010020", popped_pc); end
  endtask

  task automatic test_sp_wrap();
    pulse_reset();
    mem_push = 1; memory_write_src_select = 2'b11; LDM_value_in = 16'h5A5A;
    step();
    n_vec++; if (w_sp_out !== 11'h7FF) begin n_err++; $display("FAIL wrap_push_sp got %h exp 7ff", w_sp_out); end
    idle_inputs(); mem_pop = 1;
    step();
    n_vec++; if (w_sp_out !== 11'h000) begin n_err++; $display("FAIL wrap_pop_sp got %h exp 000", w_sp_out); end
    n_vec++; if (w_mem_data_out !== 16'h5A5A) begin n_err++; $display("FAIL wrap_pop_data got %h exp 5a5a", w_mem_data_out); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_push2();
    pulse_reset();
    mem_push = 1; memory_write_src_select = 2'b10; pc_plus_one_in = 32'hABCD_1234; reg_write = 1;
    step();
    n_vec++; if (sp_out !== 11'h7FE) begin n_err++; $display("FAIL rst2_pre_sp got %h exp 7fe", sp_out); end
    reset = 1'b0;
    #1;
    n_vec++; if (sp_out !== 11'h7FF) begin n_err++; $display("FAIL rst2_sp got %h exp 7ff", sp_out); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst2_stall got %b exp 0", stall); end
    n_vec++; if (reg_write_out !== 1'b0 || pc_load !== 1'b0) begin
      n_err++; $display("FAIL rst2_outs got %b%b exp 00", reg_write_out, pc_load); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    // Back in IDLE: the held 32-bit push request raises stall again.
    n_vec++; if (stall !== 1'b1) begin n_err++; $display("FAIL rst2_idle got %b exp 1", stall); end
    idle_inputs(); mem_read = 1; result_in = 16'h07FF;
    step();
    n_vec++; if (mem_data_out !== 16'hABCD) begin n_err++; $display("FAIL rst2_half_word got %h exp abcd", mem_data_out); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [15:0]   mdl_mem [DEPTH];
    logic [AW-1:0] mdl_sp, sp_mid, nxt, a;
    logic [15:0]   mdl_mdo, src, lo, hi;
    logic [31:0]   mdl_pc;
    bit            two, popl;
    pulse_reset();
    for (int k = 0; k < DEPTH; k++) begin
      mdl_mem[k] = 16'($urandom);
      mem_write = 1; result_in = 16'(k); read_data1_in = mdl_mem[k];
      step();
    end
    idle_inputs();
    mdl_sp = 11'h7FF; mdl_mdo = 16'h0; mdl_pc = 32'h0;
    for (int i = 0; i < 500; i++) begin
      result_in = 16'($urandom); read_data1_in = 16'($urandom);
      read_data2_in = 16'($urandom); LDM_value_in = 16'($urandom);
      pc_plus_one_in = $urandom;
      mem_push = ($urandom_range(0, 3) == 0); mem_pop = ($urandom_range(0, 3) == 0);
      mem_read = 1'($urandom); mem_write = 1'($urandom);
      memory_address_select = 2'($urandom); memory_write_src_select = 2'($urandom);
      pc_choose_memory = 1'($urandom); reg_write = 1'($urandom);
      outport_enable = 1'($urandom); wb_sel = 2'($urandom); reg_write_address = 3'($urandom);
      case (memory_write_src_select)
        2'b00: src = read_data1_in;
        2'b01: src = read_data2_in;
        2'b10: src = pc_plus_one_in[15:0];
        default: src = LDM_value_in;
      endcase
      case (memory_address_select)
        2'b01: a = read_data2_in[AW-1:0];
        2'b10: a = mdl_sp;
        default: a = result_in[AW-1:0];
      endcase
      two = 0; popl = 0;
      if (mem_push) begin
        if (memory_write_src_select == 2'b10) begin
          two = 1;
          mdl_mem[mdl_sp] = pc_plus_one_in[31:16]; mdl_sp = mdl_sp - 1'b1; sp_mid = mdl_sp;
          mdl_mem[mdl_sp] = pc_plus_one_in[15:0];  mdl_sp = mdl_sp - 1'b1;
        end else begin
          mdl_mem[mdl_sp] = src; mdl_sp = mdl_sp - 1'b1;
        end
      end else if (mem_pop) begin
        nxt = mdl_sp + 1'b1;
        if (pc_choose_memory) begin
          two = 1; popl = 1;
          lo = mdl_mem[nxt]; mdl_sp = nxt; sp_mid = mdl_sp;
          nxt = mdl_sp + 1'b1;
          hi = mdl_mem[nxt]; mdl_sp = nxt;
          mdl_pc = {hi, lo};
        end else begin
          mdl_mdo = mdl_mem[nxt]; mdl_sp = nxt;
        end
      end else begin
        if (mem_read) mdl_mdo = mdl_mem[a];
        if (mem_write) mdl_mem[a] = src;
      end
      #1;
      n_vec++; if (stall !== two) begin n_err++; $display("FAIL rnd%0d stall got %b exp %b", i, stall, two); end
      step();
      n_vec++; if (sp_out !== (two ? sp_mid : mdl_sp)) begin
        n_err++; $display("FAIL rnd%0d sp got %h exp %h", i, sp_out, two ? sp_mid : mdl_sp); end
      n_vec++; if (mem_data_out !== mdl_mdo) begin n_err++; $display("FAIL rnd%0d mdo got %h exp %h", i, mem_data_out, mdl_mdo); end
      n_vec++; if (reg_write_out !== (reg_write & ~two) || outport_enable_out !== (outport_enable & ~two)) begin
        n_err++; $display("FAIL rnd%0d ctl got %b%b exp %b%b", i, reg_write_out, outport_enable_out, reg_write & ~two, outport_enable & ~two); end
      n_vec++; if (alu_result_out !== result_in || LDM_value_out !== LDM_value_in ||
                   wb_sel_out !== wb_sel || reg_write_address_out !== reg_write_address) begin
        n_err++; $display("FAIL rnd%0d pass got %h/%h/%b/%0d", i, alu_result_out, LDM_value_out, wb_sel_out, reg_write_address_out); end
      n_vec++; if (pc_load !== 1'b0) begin n_err++; $display("FAIL rnd%0d pc_load1 got %b exp 0", i, pc_load); end
      if (two) begin
        #1;
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rnd%0d stall2 got %b exp 0", i, stall); end
        step();
        n_vec++; if (sp_out !== mdl_sp) begin n_err++; $display("FAIL rnd%0d sp2 got %h exp %h", i, sp_out, mdl_sp); end
        n_vec++; if (reg_write_out !== reg_write) begin n_err++; $display("FAIL rnd%0d regwr2 got %b exp %b", i, reg_write_out, reg_write); end
        n_vec++; if (pc_load !== popl) begin n_err++; $display("FAIL rnd%0d pc_load2 got %b exp %b", i, pc_load, popl); end
        n_vec++; if (mem_data_out !== mdl_mdo) begin n_err++; $display("FAIL rnd%0d mdo2 got %h exp %h", i, mem_data_out, mdl_mdo); end
      end
      n_vec++; if (popped_pc !== mdl_pc) begin n_err++; $display("FAIL rnd%0d popped got %h exp %h", i, popped_pc, mdl_pc); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #12;
    test_reset();
    test_write_read();
    test_push_pop16();
    test_push_pop32();
    test_sp_wrap();
    test_reset_mid_push2();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
